// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges RAW hazards, EXE branch
// resolution and the multi-cycle SRAM handshake into per-register freeze/bubble controls.
module pipeline_stall_controller #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             counters_clr,
    output logic             mem_start,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             freeze_id_exe,
    output logic             freeze_exe_mem,
    output logic             bubble_mem_wb,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;
    logic             mem_hold_s;

    // Next state and wait counter; an undefined encoding is treated as a fault.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        mem_hold_s     = 1'b0;
        mem_start      = 1'b0;
        case (state_r)
            ST_RUN: begin
                mem_hold_s = mem_access;
                mem_start  = mem_access;
                if (mem_access) begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = CNT_ONE;
                end else begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            ST_MEM_WAIT: begin
                mem_hold_s = ~mem_ready;
                if (mem_ready) begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {CNT_W{1'b0}};
                end else if (wait_cnt_r == TIMEOUT_C) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
                end
            end
            ST_ERROR: begin
                mem_hold_s  = 1'b1;
                state_nxt_s = ST_ERROR;
            end
            default: begin
                mem_hold_s  = 1'b1;
                state_nxt_s = ST_ERROR;
            end
        endcase
    end

    // Pipeline register controls: memory hold wins, then branch flush, then hazard stall.
    always_comb begin
        freeze_pc      = 1'b0;
        freeze_if_id   = 1'b0;
        flush_if_id    = 1'b0;
        bubble_id_exe  = 1'b0;
        freeze_id_exe  = 1'b0;
        freeze_exe_mem = 1'b0;
        bubble_mem_wb  = 1'b0;
        if (mem_hold_s) begin
            freeze_pc      = 1'b1;
            freeze_if_id   = 1'b1;
            freeze_id_exe  = 1'b1;
            freeze_exe_mem = 1'b1;
            bubble_mem_wb  = 1'b1;
        end else if (branch_taken) begin
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
        end else if (hazard_detected) begin
            freeze_pc     = 1'b1;
            freeze_if_id  = 1'b1;
            bubble_id_exe = 1'b1;
        end else begin
            freeze_pc = 1'b0;
        end
    end

    // Sequencer state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {CNT_W{1'b0}};
            mem_error  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            mem_error  <= mem_error | (state_nxt_s == ST_ERROR);
        end
    end

    // Saturating performance counters; clear overrides increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= {CNT_W{1'b0}};
            flush_count  <= {CNT_W{1'b0}};
        end else if (counters_clr) begin
            stall_cycles <= {CNT_W{1'b0}};
            flush_count  <= {CNT_W{1'b0}};
        end else begin
            if (freeze_pc && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (flush_if_id && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_ONE;
            end else begin
                flush_count <= flush_count;
            end
        end
    end

endmodule
